vram_write_port: RTL

//  Host-side writer into the shared 8-bit video RAM whose other port is the VGA scanout reader.

---
 rtl/video_pkg.sv | 39 +++
 rtl/vram_write_fifo.sv | 66 ++++++
 rtl/vram_write_port.sv | 127 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the host-side VRAM write path.
package video_pkg;

    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 8;
    localparam int NIBBLE_W    = 4;

    // Write-port sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        MERGE,
        RMW_WRITE
    } wr_state_t;

    // One queued host write.
    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
        logic                   nibble;
        logic                   nibble_sel;
    } vram_wr_entry_t;

    // Replace one 4-bit pixel inside a VRAM byte.
    // sel = 0: pixel lives in [7:4] (even x); sel = 1: pixel lives in [3:0] (odd x).
    function automatic logic [VRAM_DATA_W-1:0] merge_nibble(
        input logic [VRAM_DATA_W-1:0] old_byte,
        input logic [NIBBLE_W-1:0]    pixel,
        input logic                   sel
    );
        logic [VRAM_DATA_W-1:0] result;
        if (sel) begin
            result = {old_byte[7:4], pixel};
        end else begin
            result = {pixel, old_byte[3:0]};
        end
        return result;
    endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Small synchronous FIFO holding queued host writes in arrival order.
// The head entry is presented combinationally; push at edge N is visible as head in cycle N+1.
module vram_write_fifo
    import video_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  vram_wr_entry_t push_entry,
    input  logic           pop,
    output vram_wr_entry_t head,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    vram_wr_entry_t storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Qualify strobes so a stray push when full or pop when empty cannot corrupt pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = storage[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written on push.
    // NOTE: storage is deliberately not reset; count gates every use of it, and an unreset array maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/vram_write_port.sv
// Host-side writer into the shared video RAM. Queues byte and nibble writes and
// commits them only in cycles the scanout reader does not own; nibble writes use
// read-modify-write (read, merge, write) so neighbouring pixels are preserved.
module vram_write_port
    import video_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = VRAM_ADDR_W
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [ADDR_W-1:0] hostAddress,
    input  logic [7:0]        hostData,
    input  logic              hostNibble,
    input  logic              hostNibbleSel,
    input  logic              hostWrite,
    output logic              hostReady,
    output logic              busy,
    input  logic              scanoutSlot,
    output logic              memRequest,
    output logic [ADDR_W-1:0] memAddress,
    output logic [7:0]        memWriteData,
    output logic              memWriteEnable,
    input  logic [7:0]        memReadData
);

    wr_state_t      state;
    logic [7:0]     merged_byte;
    vram_wr_entry_t push_entry;
    vram_wr_entry_t head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    // Host side: accept whenever there is room.
    assign hostReady = !fifo_full;
    assign push      = hostWrite && !fifo_full;
    assign busy      = !fifo_empty || (state != IDLE);

    // Pack the host request into a queue entry.
    always_comb begin
        push_entry            = '0;
        push_entry.addr       = VRAM_ADDR_W'(hostAddress);
        push_entry.data       = hostData;
        push_entry.nibble     = hostNibble;
        push_entry.nibble_sel = hostNibbleSel;
    end

    vram_write_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (resetN),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // RAM-side drive: everything is silent in scanout-owned slots.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        memRequest     = 1'b0;
        memWriteEnable = 1'b0;
        memAddress     = '0;
        memWriteData   = '0;
        pop            = 1'b0;
        if (!scanoutSlot) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        memRequest = 1'b1;
                        memAddress = ADDR_W'(head.addr);
                        if (!head.nibble) begin
                            memWriteEnable = 1'b1;
                            memWriteData   = head.data;
                            pop            = 1'b1;
                        end
                    end
                end
                RMW_WRITE: begin
                    memRequest     = 1'b1;
                    memWriteEnable = 1'b1;
                    memAddress     = ADDR_W'(head.addr);
                    memWriteData   = merged_byte;
                    pop            = 1'b1;
                end
                default: begin
                    // MERGE only captures read data; the RAM is left alone.
                end
            endcase
        end
    end

    // Read-modify-write sequencer and merge register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            merged_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && head.nibble && !scanoutSlot) begin
                        state <= MERGE;
                    end
                end
                MERGE: begin
                    // RAM output still holds the byte addressed last cycle, whatever the slot owner is now.
                    merged_byte <= merge_nibble(memReadData, head.data[NIBBLE_W-1:0], head.nibble_sel);
                    state       <= RMW_WRITE;
                end
                RMW_WRITE: begin
                    if (!scanoutSlot) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
